// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and constants for the fifo_serial_tx FIFO-drain serial transmitter.
// Optional feature macro: FIFO_SERIAL_TX_PARITY_EN (adds an even-parity bit per frame).
package fifo_serial_tx_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned BIT_CNT_W = $clog2(DATA_W);

`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Serial bits per frame: start + data + optional parity + stop.
  localparam int unsigned FRAME_BITS = 1 + DATA_W + PARITY_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    ST_PARITY = 3'd5,
`endif
    ST_STOP   = 3'd6
  } tx_state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_baud.sv
// Baud counter for fifo_serial_tx.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear        : restart the count at 0 on the next cycle (state entry)
//   tick         : high in the last cycle of a bit period (count == CLKS_PER_BIT-1)
//   pre_tick     : high in the cycle before the last one (count == CLKS_PER_BIT-2)
module fifo_serial_tx_baud #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next count: restart on clear, wrap at CNT_MAX.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (clear || (cnt == CNT_MAX)) begin
      cnt_nxt = '0;
    end
  end

  // Flags are registered from the next count so they line up with cnt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      tick     <= 1'b0;
      pre_tick <= (CNT_PRE == '0);
    end else begin
      cnt      <= cnt_nxt;
      tick     <= (cnt_nxt == CNT_MAX);
      pre_tick <= (cnt_nxt == CNT_PRE);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops bytes from an 8-bit FIFO and sends each as an LSB-first async serial frame.
// Optional macro FIFO_SERIAL_TX_PARITY_EN inserts an even-parity bit before stop.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   fifo_empty   : FIFO empty flag (sampled only in IDLE)
//   data_in      : FIFO read data, valid the cycle after read is sampled
//   read         : one-cycle FIFO pop strobe per byte
//   tx_o         : serial line, idles high
//   busy_o       : high whenever not idle
//   tx_done_o    : one-cycle pulse in the last cycle of the stop bit
module fifo_serial_tx
  import fifo_serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] data_in,
  output logic              read,
  output logic              tx_o,
  output logic              busy_o,
  output logic              tx_done_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fifo_serial_tx: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t              state, state_nxt;
  logic [DATA_W-1:0]      shreg, shreg_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_nxt;
  logic                   read_nxt, tx_nxt, busy_nxt, done_nxt;
  logic                   baud_clear, baud_tick, baud_pre_tick;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic                   par, par_nxt;
`endif

  // Counter restarts whenever the FSM changes state.
  assign baud_clear = (state_nxt != state);

  fifo_serial_tx_baud #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear    (baud_clear),
    .tick     (baud_tick),
    .pre_tick (baud_pre_tick)
  );

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bit_nxt   = bit_cnt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    par_nxt   = par;
`endif

    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_nxt = data_in;
        bit_nxt   = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        par_nxt   = even_parity(data_in);
`endif
        state_nxt = ST_START;
      end
      ST_START: begin
        if (baud_tick) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_nxt   = bit_cnt + BIT_CNT_W'(1);
            shreg_nxt = shreg >> 1;
          end
        end
      end
`ifdef FIFO_SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state so the registers line up with it.
    tx_nxt = 1'b1;
    unique case (state_nxt)
      ST_START:  tx_nxt = 1'b0;
      ST_DATA:   tx_nxt = shreg_nxt[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
      ST_PARITY: tx_nxt = par_nxt;
`endif
      default:   tx_nxt = 1'b1;
    endcase

    read_nxt = (state_nxt == ST_REQ);
    busy_nxt = (state_nxt != ST_IDLE);
    // pre_tick in STOP means the following cycle is the last one of the stop bit.
    done_nxt = (state == ST_STOP) && baud_pre_tick;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par       <= 1'b0;
`endif
      read      <= 1'b0;
      tx_o      <= 1'b1;
      busy_o    <= 1'b0;
      tx_done_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_nxt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par       <= par_nxt;
`endif
      read      <= read_nxt;
      tx_o      <= tx_nxt;
      busy_o    <= busy_nxt;
      tx_done_o <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Scoreboard bench for fifo_serial_tx: a behavioural FIFO feeds the DUT, every written
// byte queues its expected frame, and a serial monitor rebuilds and compares each frame.
`timescale 1ns/1ps
module tb_fifo_serial_tx;

  localparam int CPB = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk        = 1'b0;
  logic       rst_i      = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] data_in    = 8'h00;
  logic       read, tx_o, busy_o, tx_done_o;
  logic       wr_en      = 1'b0;
  logic [7:0] wr_data    = 8'h00;

  always #5 clk = ~clk;

  fifo_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .fifo_empty (fifo_empty),
    .data_in    (data_in),
    .read       (read),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .tx_done_o  (tx_done_o)
  );

  // Behavioural FIFO: registered read data and empty flag.
  byte unsigned fifo_q[$];
  always @(posedge clk) begin
    if (read && fifo_q.size() > 0) data_in <= fifo_q.pop_front();
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Stimulus-owned scoreboard state (-1 marks a frame expected to be cut by reset).
  int exp_q[$];
  int exp_reads  = 0;
  int exp_done   = 0;
  int burst_lo   = -1;
  int burst_hi   = -1;
  int n_timeouts = 0;
  bit stall      = 1'b0;
  bit end_req    = 1'b0;

  // Monitor-owned state.
  int n_chk = 0, n_err = 0;
  int exp_idx = 0, rd_cnt = 0, done_cnt = 0;
  int cyc = 0, last_end = -1, last_rd = -100, pos = 0, cur = -1;
  bit in_frame = 1'b0, post_frame = 1'b0, rst_prev = 1'b0, end_ack = 1'b0;
  int bits[NBITS];

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (end_req && !end_ack) begin
      chk(exp_idx == exp_q.size(), "frames_seen", exp_idx, exp_q.size());
      chk(rd_cnt == exp_reads, "read_count", rd_cnt, exp_reads);
      chk(done_cnt == exp_done, "done_count", done_cnt, exp_done);
      chk(n_timeouts == 0, "wait_timeouts", n_timeouts, 0);
      end_ack = 1'b1;
    end
    if (rst_prev) begin
      chk(tx_o === 1'b1, "rst_tx", int'(tx_o), 1);
      chk(read === 1'b0, "rst_read", int'(read), 0);
      chk(busy_o === 1'b0, "rst_busy", int'(busy_o), 0);
      chk(tx_done_o === 1'b0, "rst_done", int'(tx_done_o), 0);
    end
    rst_prev = rst_i;
    if (rst_i) begin
      in_frame   = 1'b0;
      post_frame = 1'b0;
    end else begin
      if (read === 1'b1) begin
        chk(fifo_q.size() > 0, "pop_when_empty", fifo_q.size(), 1);
        rd_cnt++;
        last_rd = cyc;
      end
      if (tx_done_o === 1'b1) done_cnt++;
      if (stall) begin
        chk(read === 1'b0, "stall_read", int'(read), 0);
        chk(busy_o === 1'b0, "stall_busy", int'(busy_o), 0);
      end
      if (post_frame) begin
        chk(busy_o === 1'b0, "busy_after_done", int'(busy_o), 0);
        post_frame = 1'b0;
      end
      if (!in_frame && tx_o === 1'b0) begin
        if (exp_idx < exp_q.size()) begin
          cur = exp_q[exp_idx];
          exp_idx++;
        end else begin
          chk(1'b0, "unexpected_frame", exp_idx, exp_q.size());
          cur = -1;
        end
        chk(cyc - last_rd == 2, "read_to_start", cyc - last_rd, 2);
        if (last_end >= 0) begin
          chk(cyc - last_end - 1 >= 3, "gap_min", cyc - last_end - 1, 3);
          if ((exp_idx - 1) > burst_lo && (exp_idx - 1) < burst_hi)
            chk(cyc - last_end - 1 == 3, "burst_gap", cyc - last_end - 1, 3);
        end
        bits[0] = 0;
        for (int i = 0; i < 8; i++) bits[1 + i] = (cur >> i) & 1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        bits[9] = ((cur & 8'hFF) == 0) ? 0 : ($countones(cur & 8'hFF) % 2);
`endif
        bits[NBITS - 1] = 1;
        in_frame = 1'b1;
        pos = 0;
      end
      if (in_frame) begin
        if (cur >= 0)
          chk(tx_o === bits[pos / CPB][0], "tx_bit", int'(tx_o), bits[pos / CPB]);
        chk(tx_done_o === (pos == FRAME_CYC - 1), "done_pulse", int'(tx_done_o),
            int'(pos == FRAME_CYC - 1));
        chk(busy_o === 1'b1, "busy_in_frame", int'(busy_o), 1);
        pos++;
        if (pos == FRAME_CYC) begin
          in_frame   = 1'b0;
          last_end   = cyc;
          post_frame = 1'b1;
        end
      end else begin
        chk(tx_done_o === 1'b0, "done_idle", int'(tx_done_o), 0);
        chk(tx_o === 1'b1, "tx_idle", int'(tx_o), 1);
      end
    end
  end

  // Queue one FIFO write in the next cycle; end_writes releases the write port.
  task automatic write_byte(input logic [7:0] b, input bit completes);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_data = b;
    exp_reads++;
    if (completes) begin
      exp_q.push_back(int'(b));
      exp_done++;
    end else begin
      exp_q.push_back(-1);
    end
  endtask

  task automatic end_writes();
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_idx == exp_q.size() && !in_frame && busy_o === 1'b0 && fifo_empty)) begin
      @(posedge clk);
      n++;
      if (n > 5000) begin
        n_timeouts++;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset held while the FIFO is non-empty: no pop may happen.
    write_byte(8'h11, 1'b1);
    end_writes();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    drain();

    // Directed bytes (parity 0 and 1 when parity is compiled in).
    write_byte(8'hA5, 1'b1);
    end_writes();
    drain();
    write_byte(8'h07, 1'b1);
    end_writes();
    drain();

    // Random bytes with random spacing.
    for (int i = 0; i < 20; i++) begin
      write_byte(8'($urandom_range(0, 255)), 1'b1);
      end_writes();
      repeat ($urandom_range(0, 50)) @(posedge clk);
    end
    drain();

    // Burst 0x03..0x34 back to back.
    burst_lo = exp_q.size();
    burst_hi = burst_lo + 50;
    for (int i = 0; i < 50; i++) write_byte(8'(8'h03 + i), 1'b1);
    end_writes();
    drain();

    // Empty stall.
    stall = 1'b1;
    repeat (100) @(posedge clk);
    #1 stall = 1'b0;

    // Reset during data bit 3 of 0xA5, then 0x5A must go out without a re-read.
    write_byte(8'hA5, 1'b0);
    write_byte(8'h5A, 1'b1);
    end_writes();
    n = 0;
    while (tx_o !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) n_timeouts++;
    repeat (4 * CPB + 1) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    drain();

    end_req = 1'b1;
    n = 0;
    while (!end_ack && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (!end_ack) begin
      $display("FAIL end_handshake: got 0, want 1");
      $fatal(1, "monitor did not respond");
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
